// File: rtl/reg_write_port.sv
// Write-side controller for the register file: in-order write FIFO, one registered
// load/Caddr/C write per cycle, a zeroing (drain + scrub) sequence and A/B hazard forwarding.
module reg_write_port #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              zero_req,
  output logic              scrub_busy,
  input  logic [ADDR_W-1:0] Aaddr,
  input  logic [ADDR_W-1:0] Baddr,
  output logic              pend_a,
  output logic              pend_b,
  output logic [DATA_W-1:0] fwd_a,
  output logic [DATA_W-1:0] fwd_b,
  output logic              load,
  output logic [ADDR_W-1:0] Caddr,
  output logic [DATA_W-1:0] C
);

  localparam int                PTR_W     = $clog2(DEPTH);
  localparam int                CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {RUN, DRAIN, SCRUB} state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PTR_W-1:0]  wptr_q, rptr_q, idx;
  logic [CNT_W-1:0]  count_q;
  logic              empty, full, push, pop;

  assign empty      = (count_q == '0);
  assign full       = (count_q == FULL_CNT);
  assign wr_ready   = (state_q == RUN) && !full;
  assign push       = wr_valid && wr_ready;
  assign pop        = ((state_q == RUN) || (state_q == DRAIN)) && !empty;
  assign scrub_busy = (state_q != RUN);

  // During SCRUB the output register Caddr doubles as the scrub address counter.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (zero_req) state_d = DRAIN;
      DRAIN:   if (empty) state_d = SCRUB;
      SCRUB:   if (Caddr == LAST_ADDR) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= RUN;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= rptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the FIFO storage is not reset; entries are only ever read under count_q, which is.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wptr_q] <= wr_addr;
      mem_data[wptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      load  <= 1'b0;
      Caddr <= '0;
      C     <= '0;
    end else if ((state_q == DRAIN) && empty) begin
      load  <= 1'b1;
      Caddr <= '0;
      C     <= '0;
    end else if ((state_q == SCRUB) && (Caddr != LAST_ADDR)) begin
      load  <= 1'b1;
      Caddr <= Caddr + ADDR_W'(1);
      C     <= '0;
    end else if (pop) begin
      load  <= 1'b1;
      Caddr <= mem_addr[rptr_q];
      C     <= mem_data[rptr_q];
    end else begin
      load  <= 1'b0;
    end
  end

  // Oldest-to-youngest scan: later matches overwrite earlier ones, so the youngest
  // FIFO entry wins over older entries and over the output stage.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    pend_a = 1'b0;
    pend_b = 1'b0;
    fwd_a  = '0;
    fwd_b  = '0;
    idx    = rptr_q;
    if (load && (Caddr == Aaddr)) begin
      pend_a = 1'b1;
      fwd_a  = C;
    end
    if (load && (Caddr == Baddr)) begin
      pend_b = 1'b1;
      fwd_b  = C;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = rptr_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) begin
        if (mem_addr[idx] == Aaddr) begin
          pend_a = 1'b1;
          fwd_a  = mem_data[idx];
        end
        if (mem_addr[idx] == Baddr) begin
          pend_b = 1'b1;
          fwd_b  = mem_data[idx];
        end
      end
    end
    if (state_q != RUN) begin
      pend_a = 1'b1;
      pend_b = 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_write_port.sv
// Self-checking bench for reg_write_port: directed scenarios plus random traffic,
// compared every cycle against a queue-based model of the write port.
module tb_reg_write_port;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        clear, wr_valid, wr_ready, zero_req, scrub_busy;
  logic [3:0]  wr_addr, Aaddr, Baddr, Caddr;
  logic [15:0] wr_data, fwd_a, fwd_b, C;
  logic        pend_a, pend_b, load;

  reg_write_port #(.DATA_W(16), .ADDR_W(4), .DEPTH(DEPTH)) dut (
    .clk(clk), .clear(clear), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .zero_req(zero_req), .scrub_busy(scrub_busy),
    .Aaddr(Aaddr), .Baddr(Baddr), .pend_a(pend_a), .pend_b(pend_b),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .load(load), .Caddr(Caddr), .C(C)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] data;
  } wr_t;
  typedef enum {M_RUN, M_DRAIN, M_SCRUB} mode_t;

  // Reference model: pending writes, pending scrub writes, and the visible output stage.
  wr_t         q[$];
  wr_t         scrub_q[$];
  mode_t       mode;
  logic        e_load;
  logic [3:0]  e_caddr;
  logic [15:0] e_c;
  logic [15:0] rf_dut [16];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk     = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] m_hazard(input logic [3:0] x);
    logic        p = 1'b0;
    logic [15:0] f = 16'h0;
    bit          hit = 1'b0;
    for (int i = q.size() - 1; i >= 0 && !hit; i--) begin
      if (q[i].addr == x) begin
        p = 1'b1;
        f = q[i].data;
        hit = 1'b1;
      end
    end
    if (!hit && e_load && (e_caddr == x)) begin
      p = 1'b1;
      f = e_c;
    end
    if (mode != M_RUN) p = 1'b1;
    return {p, f};
  endfunction

  task automatic model_edge(input logic v, input logic [3:0] a, input logic [15:0] d,
                            input logic z, input logic clr);
    mode_t m0;
    bit    acc;
    wr_t   w;
    if (clr) begin
      q.delete();
      scrub_q.delete();
      mode    = M_RUN;
      e_load  = 1'b0;
      e_caddr = 4'h0;
      e_c     = 16'h0;
      return;
    end
    m0  = mode;
    acc = v && (m0 == M_RUN) && (q.size() < DEPTH);
    if (m0 == M_DRAIN && q.size() == 0) begin
      for (int i = 0; i < 16; i++) scrub_q.push_back('{addr: 4'(i), data: 16'h0});
      mode = M_SCRUB;
    end
    if (mode == M_SCRUB && scrub_q.size() == 0) mode = M_RUN;
    if (mode == M_SCRUB) begin
      w = scrub_q.pop_front();
      e_load = 1'b1; e_caddr = w.addr; e_c = w.data;
    end else if (q.size() > 0) begin
      w = q.pop_front();
      e_load = 1'b1; e_caddr = w.addr; e_c = w.data;
    end else begin
      e_load = 1'b0;
    end
    if (acc) q.push_back('{addr: a, data: d});
    if (m0 == M_RUN && z) mode = M_DRAIN;
  endtask

  // One clock cycle: drive inputs, check every output against the model, advance both.
  task automatic cycle(input logic v, input logic [3:0] a, input logic [15:0] d,
                       input logic z, input logic clr, input logic [3:0] ra, input logic [3:0] rb);
    logic [16:0] ha, hb;
    logic        s_load;
    logic [3:0]  s_caddr;
    logic [15:0] s_c;
    wr_valid = v; wr_addr = a; wr_data = d; zero_req = z; clear = clr; Aaddr = ra; Baddr = rb;
    #1;
    s_load = load; s_caddr = Caddr; s_c = C;
    if (chk) begin
      ha = m_hazard(ra);
      hb = m_hazard(rb);
      check("wr_ready",   wr_ready,   (mode == M_RUN) && (q.size() < DEPTH));
      check("scrub_busy", scrub_busy, mode != M_RUN);
      check("load",       load,       e_load);
      if (e_load) begin
        check("Caddr", Caddr, e_caddr);
        check("C",     C,     e_c);
      end
      check("pend_a", pend_a, ha[16]);
      check("fwd_a",  fwd_a,  ha[15:0]);
      check("pend_b", pend_b, hb[16]);
      check("fwd_b",  fwd_b,  hb[15:0]);
    end
    @(posedge clk);
    model_edge(v, a, d, z, clr);
    if (chk && s_load) rf_dut[s_caddr] = s_c;
    #1;
  endtask

  task automatic idle(input int n, input logic [3:0] ra, input logic [3:0] rb);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 16'h0, 1'b0, 1'b0, ra, rb);
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 16; i++) rf_dut[i] = 16'hFFFF;

    // Reset
    cycle(1'b0, 4'h0, 16'h0, 1'b0, 1'b1, 4'h0, 4'h0);
    chk = 1'b1;
    cycle(1'b0, 4'h0, 16'h0, 1'b0, 1'b1, 4'h0, 4'h0);
    check("rst_load",  load,     1'b0);
    check("rst_caddr", Caddr,    4'h0);
    check("rst_c",     C,        16'h0);
    check("rst_ready", wr_ready, 1'b1);

    // T1: single write
    cycle(1'b1, 4'd3, 16'hBEEF, 1'b0, 1'b0, 4'd3, 4'd0);
    check("t1_not_yet", load, 1'b0);
    cycle(1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 4'd3, 4'd0);
    check("t1_load",  load,  1'b1);
    check("t1_caddr", Caddr, 4'd3);
    check("t1_c",     C,     16'hBEEF);
    check("t1_fwd_a", fwd_a, 16'hBEEF);
    idle(2, 4'd3, 4'd0);

    // T2: back-to-back stream of five writes
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 4'(i + 8), 16'(16'h1000 + i), 1'b0, 1'b0, 4'(i + 8), 4'd9);
    idle(4, 4'd12, 4'd11);

    // T3: duplicate address, youngest forwarded
    cycle(1'b1, 4'd5, 16'h0001, 1'b0, 1'b0, 4'd0, 4'd5);
    cycle(1'b1, 4'd5, 16'h0002, 1'b0, 1'b0, 4'd0, 4'd5);
    check("t3_fwd_b", fwd_b, 16'h0002);
    idle(3, 4'd0, 4'd5);
    check("t3_clear_pend", pend_b, 1'b0);

    // T4: two queued writes, then zeroing sequence
    cycle(1'b1, 4'd7, 16'hAAAA, 1'b0, 1'b0, 4'd7, 4'd8);
    cycle(1'b1, 4'd8, 16'h5555, 1'b1, 1'b0, 4'd7, 4'd8);
    idle(22, 4'd7, 4'd15);
    for (int i = 0; i < 16; i++) check($sformatf("t4_rf%0d", i), rf_dut[i], 16'h0);

    // T5: clear in the middle of the scrub
    cycle(1'b0, 4'd0, 16'h0, 1'b1, 1'b0, 4'd2, 4'd7);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (load && Caddr == 4'd7 && scrub_busy) found = 1'b1;
      else idle(1, 4'd2, 4'd7);
    end
    check("t5_reached_step7", found, 1'b1);
    cycle(1'b0, 4'd0, 16'h0, 1'b0, 1'b1, 4'd2, 4'd7);
    check("t5_load",  load,       1'b0);
    check("t5_busy",  scrub_busy, 1'b0);
    check("t5_ready", wr_ready,   1'b1);
    check("t5_pend",  {pend_a, pend_b}, 2'b00);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
            4'($urandom_range(0, 5)), 16'($urandom),
            ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0,
            4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)));
    end
    idle(25, 4'd0, 4'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
